// File: rtl/key_reader_pkg.sv
// Shared defaults and event-entry layout for the push-button reader.
package key_reader_pkg;
  localparam int NKEYS_DEF           = 4;
  localparam int DEBOUNCE_CYCLES_DEF = 1000000;
  localparam int FIFO_DEPTH_DEF      = 4;

  // Event entry is {key, press}: press in bit 0, key index above it.
  localparam int EVT_KEY_W = $clog2(NKEYS_DEF);
  localparam int EVT_W     = EVT_KEY_W + 1;

  typedef struct packed {
    logic [EVT_KEY_W-1:0] key;
    logic                 press;
  } evt_t;

  // Key index width, kept at least 1 so a single-key build still has a field.
  function automatic int key_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/key_debounce.sv
// One button: 2-flop synchronizer, stability counter and debounced level.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_n_i,
  output logic level_o,
  output logic toggle_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          pressed;

  assign pressed = ~sync_q[1];
  assign level_o = level_q;

  // Toggle fires on the edge the counter would reach DEBOUNCE_CYCLES.
  always_comb begin
    cnt_d    = '0;
    level_d  = level_q;
    toggle_o = 1'b0;
    if (pressed != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        level_d  = pressed;
        toggle_o = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], key_n_i};
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end
endmodule

// File: rtl/key_reader.sv
// Debounced push-buttons with press/release events queued in a small FIFO.
module key_reader
  import key_reader_pkg::*;
#(
  parameter int NKEYS           = NKEYS_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int FIFO_DEPTH      = FIFO_DEPTH_DEF,
  localparam int KW             = key_w(NKEYS)
) (
  input  logic             CLOCK_50,
  input  logic             KEY0,
  input  logic [NKEYS-1:0] KEY_N,
  output logic [NKEYS-1:0] key_level,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [KW-1:0]    evt_key,
  output logic             evt_press,
  output logic             overflow,
  input  logic             clr_ovf
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [KW-1:0] key;
    logic          press;
  } entry_t;

  logic [NKEYS-1:0] lvl, tog;
  logic [NKEYS-1:0] pend_q, pend_d, dir_q, dir_d;
  logic             ovf_q, ovf_d, ovf_set;
  logic [AW:0]      wr_q, rd_q;
  entry_t           mem_q [FIFO_DEPTH];
  entry_t           head;
  logic             empty, full, push, pop, gnt_any;
  logic [KW-1:0]    gidx;

  for (genvar g = 0; g < NKEYS; g++) begin : g_key
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk_i   (CLOCK_50),
      .rst_ni  (KEY0),
      .key_n_i (KEY_N[g]),
      .level_o (lvl[g]),
      .toggle_o(tog[g])
    );
  end

  assign key_level = lvl;
  assign empty     = (wr_q == rd_q);
  assign full      = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign evt_valid = ~empty;
  assign pop       = evt_valid & evt_ready;
  assign head      = mem_q[rd_q[AW-1:0]];
  assign evt_key   = evt_valid ? head.key : '0;
  assign evt_press = evt_valid & head.press;
  assign overflow  = ovf_q;

  // Lowest-index pending key wins; a pop frees a slot for a same-cycle push.
  always_comb begin
    gnt_any = 1'b0;
    gidx    = '0;
    for (int i = NKEYS - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        gnt_any = 1'b1;
        gidx    = KW'(i);
      end
    end
    push = gnt_any && (!full || pop);
  end

  // An event is lost only when a key re-toggles before its pending one was queued.
  always_comb begin
    pend_d  = pend_q;
    dir_d   = dir_q;
    ovf_set = 1'b0;
    for (int i = 0; i < NKEYS; i++) begin
      if (push && gidx == KW'(i)) pend_d[i] = 1'b0;
      if (tog[i]) begin
        pend_d[i] = 1'b1;
        dir_d[i]  = ~lvl[i];
        if (pend_q[i] && !(push && gidx == KW'(i))) ovf_set = 1'b1;
      end
    end
    ovf_d = ovf_set ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);
  end

  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      pend_q <= '0;
      dir_q  <= '0;
      ovf_q  <= 1'b0;
      wr_q   <= '0;
      rd_q   <= '0;
    end else begin
      pend_q <= pend_d;
      dir_q  <= dir_d;
      ovf_q  <= ovf_d;
      wr_q   <= wr_q + (AW+1)'(push);
      rd_q   <= rd_q + (AW+1)'(pop);
    end
  end

  // Storage needs no reset: the head fields are masked while the queue is empty.
  always_ff @(posedge CLOCK_50) begin
    if (push) mem_q[wr_q[AW-1:0]] <= '{key: gidx, press: dir_q[gidx]};
  end
endmodule

// File: tb/tb_key_reader.sv
// Directed bench for key_reader with a short debounce window.
module tb_key_reader;
  logic       CLOCK_50 = 1'b0;
  logic       KEY0 = 1'b0;
  logic [3:0] KEY_N = 4'hF;
  logic [3:0] key_level;
  logic       evt_valid, evt_press, overflow;
  logic       evt_ready = 1'b0, clr_ovf = 1'b0;
  logic [1:0] evt_key;
  int passed = 0, total = 0;

  key_reader #(.NKEYS(4), .DEBOUNCE_CYCLES(8), .FIFO_DEPTH(4)) dut (
    .CLOCK_50(CLOCK_50), .KEY0(KEY0), .KEY_N(KEY_N), .key_level(key_level),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_key(evt_key),
    .evt_press(evt_press), .overflow(overflow), .clr_ovf(clr_ovf));

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge CLOCK_50); #1; end
  endtask

  task automatic do_reset();
    KEY0 = 1'b0; KEY_N = 4'hF; evt_ready = 1'b0; clr_ovf = 1'b0;
    tick(3);
    KEY0 = 1'b1;
    tick(1);
  endtask

  task automatic test_reset();
    KEY0 = 1'b0;
    tick(3);
    total++;
    if ({key_level, evt_valid, evt_key, evt_press, overflow} !== 9'd0)
      $display("FAIL reset_outputs got %b exp 0", {key_level, evt_valid, evt_key, evt_press, overflow});
    else passed++;
    KEY0 = 1'b1;
    tick(1);
  endtask

  task automatic test_glitch();
    KEY_N[1] = 1'b0; tick(3);
    KEY_N[1] = 1'b1; tick(2);
    KEY_N[1] = 1'b0; tick(9);
    total++;
    if (key_level !== 4'b0000) $display("FAIL glitch_early got %b exp 0000", key_level);
    else passed++;
    tick(1);
    total++;
    if (key_level !== 4'b0010) $display("FAIL glitch_rise got %b exp 0010", key_level);
    else passed++;
    total++;
    if (evt_valid !== 1'b0) $display("FAIL glitch_no_bypass got %b exp 0", evt_valid);
    else passed++;
    tick(1);
    total++;
    if ({evt_valid, evt_key, evt_press} !== 4'b1_01_1)
      $display("FAIL glitch_event got %b exp 1011", {evt_valid, evt_key, evt_press});
    else passed++;
    evt_ready = 1'b1; tick(1); evt_ready = 1'b0;
    tick(12);
    total++;
    if (evt_valid !== 1'b0) $display("FAIL glitch_single_event got %b exp 0", evt_valid);
    else passed++;
  endtask

  task automatic test_short_pulse();
    logic bad;
    do_reset();
    bad = 1'b0;
    KEY_N[2] = 1'b0; tick(7);
    KEY_N[2] = 1'b1;
    repeat (20) begin
      tick(1);
      if (key_level[2] !== 1'b0 || evt_valid !== 1'b0) bad = 1'b1;
    end
    total++;
    if (bad !== 1'b0) $display("FAIL short_pulse got %b exp 0", bad);
    else passed++;
  endtask

  task automatic test_simultaneous();
    do_reset();
    evt_ready = 1'b1;
    KEY_N = 4'b0110;
    tick(10);
    total++;
    if (key_level !== 4'b1001) $display("FAIL simul_level got %b exp 1001", key_level);
    else passed++;
    tick(1);
    total++;
    if ({evt_valid, evt_key, evt_press} !== 4'b1_00_1)
      $display("FAIL simul_first got %b exp 1001", {evt_valid, evt_key, evt_press});
    else passed++;
    tick(1);
    total++;
    if ({evt_valid, evt_key, evt_press} !== 4'b1_11_1)
      $display("FAIL simul_second got %b exp 1111", {evt_valid, evt_key, evt_press});
    else passed++;
    tick(1);
    total++;
    if (evt_valid !== 1'b0) $display("FAIL simul_drained got %b exp 0", evt_valid);
    else passed++;
    evt_ready = 1'b0;
  endtask

  task automatic test_overflow();
    logic [1:0] ek [5] = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd2};
    logic       ep [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    KEY_N = 4'b0100; tick(14);
    KEY_N[0] = 1'b1; tick(14);
    KEY_N[2] = 1'b0; tick(14);
    total++;
    if ({key_level, overflow} !== 5'b1110_0)
      $display("FAIL ovf_before got %b exp 11100", {key_level, overflow});
    else passed++;
    KEY_N[2] = 1'b1; tick(9);
    clr_ovf = 1'b1; tick(1); clr_ovf = 1'b0;
    total++;
    if ({key_level, overflow} !== 5'b1010_1)
      $display("FAIL ovf_set_wins got %b exp 10101", {key_level, overflow});
    else passed++;
    tick(4);
    evt_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({evt_valid, evt_key, evt_press} !== {1'b1, ek[i], ep[i]})
        $display("FAIL ovf_drain%0d got %b exp %b", i, {evt_valid, evt_key, evt_press}, {1'b1, ek[i], ep[i]});
      else passed++;
      tick(1);
    end
    evt_ready = 1'b0;
    total++;
    if ({evt_valid, overflow} !== 2'b01)
      $display("FAIL ovf_sticky got %b exp 01", {evt_valid, overflow});
    else passed++;
    clr_ovf = 1'b1; tick(1); clr_ovf = 1'b0;
    total++;
    if (overflow !== 1'b0) $display("FAIL ovf_clear got %b exp 0", overflow);
    else passed++;
  endtask

  task automatic test_full_push_pop();
    logic [1:0] ek [4] = '{2'd1, 2'd3, 2'd0, 2'd2};
    logic       ep [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    do_reset();
    KEY_N = 4'b0100; tick(14);
    KEY_N[0] = 1'b1; tick(14);
    KEY_N[2] = 1'b0; tick(14);
    evt_ready = 1'b1;
    total++;
    if ({evt_valid, evt_key, evt_press} !== 4'b1_00_1)
      $display("FAIL fpp_head got %b exp 1001", {evt_valid, evt_key, evt_press});
    else passed++;
    tick(1);
    evt_ready = 1'b0;
    tick(3);
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({evt_valid, evt_key, evt_press} !== {1'b1, ek[i], ep[i]})
        $display("FAIL fpp_drain%0d got %b exp %b", i, {evt_valid, evt_key, evt_press}, {1'b1, ek[i], ep[i]});
      else passed++;
      evt_ready = 1'b1; tick(1); evt_ready = 1'b0;
    end
    total++;
    if ({evt_valid, overflow} !== 2'b00)
      $display("FAIL fpp_end got %b exp 00", {evt_valid, overflow});
    else passed++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    KEY_N = 4'b0111; tick(14);
    total++;
    if (evt_valid !== 1'b1) $display("FAIL rmid_prefill got %b exp 1", evt_valid);
    else passed++;
    KEY_N = 4'b0101; tick(7);
    #2 KEY0 = 1'b0;
    #1;
    total++;
    if ({key_level, evt_valid, evt_key, evt_press, overflow} !== 9'd0)
      $display("FAIL rmid_async got %b exp 0", {key_level, evt_valid, evt_key, evt_press, overflow});
    else passed++;
    tick(2);
    KEY0 = 1'b1;
    tick(9);
    total++;
    if (key_level !== 4'b0000) $display("FAIL rmid_early got %b exp 0000", key_level);
    else passed++;
    tick(1);
    total++;
    if (key_level !== 4'b1010) $display("FAIL rmid_rise got %b exp 1010", key_level);
    else passed++;
    tick(1);
    total++;
    if ({evt_valid, evt_key, evt_press} !== 4'b1_01_1)
      $display("FAIL rmid_event got %b exp 1011", {evt_valid, evt_key, evt_press});
    else passed++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_glitch();
    test_short_pulse();
    test_simultaneous();
    test_overflow();
    test_full_push_pop();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/key_reader.md
KEY_READER -- requirements
Module: key_reader

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: CLOCK_50 clocks all state and KEY0 resets all state.
REQ-002 The block SHALL have parameter NKEYS, default 4: number of raw push-buttons.
REQ-003 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000000: consecutive stable cycles needed to accept a change (20 ms at 50 MHz); minimum value NKEYS.
REQ-004 The block SHALL have parameter FIFO_DEPTH, default 4: event queue depth, a power of 2.
REQ-005 The block SHALL have port CLOCK_50  in  1  50 MHz system clock.
REQ-006 The block SHALL have port KEY0  in  1  async active-low reset.
REQ-007 The block SHALL have port KEY_N  in  NKEYS  raw active-low buttons, asynchronous to CLOCK_50.
REQ-008 The block SHALL have port key_level  out  NKEYS  debounced state, 1=pressed.
REQ-009 The block SHALL have port evt_valid  out  1  event available at queue head.
REQ-010 The block SHALL have port evt_ready  in  1  consumer accepts head event.
REQ-011 The block SHALL have port evt_key  out  clog2(NKEYS)  key index of head event.
REQ-012 The block SHALL have port evt_press  out  1  head event direction: 1=press, 0=release.
REQ-013 The block SHALL have port overflow  out  1  sticky lost-event flag.
REQ-014 The block SHALL have port clr_ovf  in  1  synchronous clear of overflow.

Function
REQ-015 Each KEY_N bit SHALL pass through a 2-flop synchronizer; the synced value is inverted to pressed polarity.
REQ-016 Per key, the counter SHALL reset to 0 in any cycle where synced equals key_level, and increment otherwise.
REQ-017 key_level SHALL toggle, and the counter clear, on the edge where the counter would reach DEBOUNCE_CYCLES, giving a latency from raw edge to key_level of exactly 2+DEBOUNCE_CYCLES cycles for a clean input.
REQ-018 Each key_level toggle SHALL set that key's pending flag and record its direction in the same edge.
REQ-019 Each cycle, the lowest-index pending key SHALL be pushed to the FIFO and its pending flag cleared, if the FIFO is not full or a pop occurs in that cycle.
REQ-020 If a key toggles while its pending flag is already set, the block SHALL overwrite the stored direction with the new one and set overflow.
REQ-021 evt_valid SHALL equal FIFO not-empty; a pop occurs when evt_valid and evt_ready are both 1.
REQ-022 evt_key and evt_press SHALL hold the head entry and stay stable while evt_valid=1 and evt_ready=0.
REQ-023 Simultaneous push and pop SHALL be allowed when empty, partial or full; an empty-FIFO push is visible on evt_valid the next cycle, with no bypass.
REQ-024 overflow SHALL be set per REQ-020 and cleared by clr_ovf; if set and clear coincide, set wins.
REQ-025 FIFO pointers SHALL carry one extra wrap bit; full = indices equal and wrap bits differ.

Reset
REQ-026 While KEY0=0 the block SHALL force: synchronizer flops=1 (released), counters=0, key_level=0, pending=0, FIFO empty (evt_valid=0, evt_key=0, evt_press=0), overflow=0.
REQ-027 Asserting reset mid-debounce or with a non-empty FIFO SHALL discard all in-flight state.
REQ-028 A key held through reset deassertion SHALL be reported as a press 2+DEBOUNCE_CYCLES cycles after deassertion.

Structure
REQ-029 Package key_reader_pkg SHALL hold the default constants (NKEYS, DEBOUNCE_CYCLES, FIFO_DEPTH) and the event entry width/field layout {key, press}.
REQ-030 Sub-module key_debounce, containing the synchronizer, counter and stable bit for one key, SHALL be instantiated NKEYS times via generate; pending, arbiter and FIFO stay in key_reader.

Verification (DEBOUNCE_CYCLES=8, FIFO_DEPTH=4, NKEYS=4)
REQ-031 KEY_N[1] low 3 cycles, high 2 cycles, then low steady -> key_level[1] rises exactly 10 cycles after the final falling edge; exactly one event, key=1 press=1.
REQ-032 KEY_N[2] low-pulse of 7 cycles -> key_level[2] never changes, evt_valid stays 0.
REQ-033 KEY_N[0] and KEY_N[3] fall in the same cycle, evt_ready=1 -> events key0 press and key3 press on consecutive cycles, in that order.
REQ-034 evt_ready=0; generate 4 events (FIFO full), then a key2 press and later a key2 release -> overflow=1; with evt_ready=1 the bench sees the 4 queued events, then key2 press=0; clr_ovf -> overflow=0.
REQ-035 FIFO full, evt_ready=1 and a new pending event in the same cycle -> pop and push both occur, count stays 4, no overflow.
REQ-036 KEY0 asserted with KEY_N[1] low and its counter at 5 -> all outputs at reset values; KEY0 released with the key still low -> press event key=1, with key_level[1] rising exactly 10 cycles after release.
